note_lookup_scheduler: RTL and testbench

Round-robin scheduler that shares one `note_address` lookup unit among three chord voices. Each voice requests a lookup by presenting a 6-bit note and holding a request. The block serialises requests onto the single lookup port and registers the 45-bit result into that voice's address register. It then pulses a per-voice done strobe. It sits between the song/chord sequencing logic and the per-voice note players, so only one `note_address` instance is needed.

---
 rtl/note_lookup_scheduler_if.sv | 26 ++
 rtl/note_lookup_scheduler.sv | 97 +++++++++
 tb/tb_note_lookup_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/note_lookup_scheduler_if.sv
// Bundle between the voice sequencers, the scheduler and the shared note_address unit.
// The master side is the environment (voices plus lookup unit); the slave side is the scheduler.
interface note_lookup_scheduler_if #(
  parameter int NOTE_W = 6,
  parameter int ADDR_W = 45
);
  logic [2:0]          req;
  logic [3*NOTE_W-1:0] notes;
  logic [2:0]          done;
  logic [ADDR_W-1:0]   addr0;
  logic [ADDR_W-1:0]   addr1;
  logic [ADDR_W-1:0]   addr2;
  logic [NOTE_W-1:0]   lookup_note;
  logic [ADDR_W-1:0]   lookup_addr;
  logic                busy;

  modport master (
    output req, notes, lookup_addr,
    input  done, addr0, addr1, addr2, lookup_note, busy
  );

  modport slave (
    input  req, notes, lookup_addr,
    output done, addr0, addr1, addr2, lookup_note, busy
  );
endinterface

// File: rtl/note_lookup_scheduler.sv
// Round-robin sharing of one note_address lookup among three voices; the grant of one voice
// overlaps the capture of the previous one, so the lookup port can be used every cycle.
module note_lookup_scheduler (
  input  logic                    clk,
  input  logic                    reset,
  note_lookup_scheduler_if.slave  bus
);
  localparam int NOTE_W = 6;
  localparam int ADDR_W = 45;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          sel_q, sel_d;
  logic [NOTE_W-1:0]   lookupNote_q, lookupNote_d;
  logic [2:0]          done_q, done_d;
  logic [ADDR_W-1:0]   addr_q [3];
  logic [ADDR_W-1:0]   addr_d [3];

  logic [2:0]          eligible;
  logic [1:0]          cand0, cand1, cand2;
  logic [1:0]          winner;
  logic                grant;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      lookupNote_q <= '0;
      done_q       <= '0;
      for (int i = 0; i < 3; i++) addr_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      lookupNote_q <= lookupNote_d;
      done_q       <= done_d;
      for (int i = 0; i < 3; i++) addr_q[i] <= addr_d[i];
    end
  end

  always_comb begin
    state_d      = IDLE;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    lookupNote_d = lookupNote_q;
    done_d       = '0;
    for (int i = 0; i < 3; i++) addr_d[i] = addr_q[i];
    eligible     = '0;
    grant        = 1'b0;
    winner       = ptr_q;

    // The voice in flight and the voice showing done are blocked so a held req is not served twice.
    for (int i = 0; i < 3; i++) begin
      eligible[i] = bus.req[i] && !((state_q == BUSY) && (sel_q == 2'(i))) && !done_q[i];
    end

    cand0 = ptr_q;
    cand1 = inc3(cand0);
    cand2 = inc3(cand1);
    if (eligible[cand0]) begin
      grant  = 1'b1;
      winner = cand0;
    end else if (eligible[cand1]) begin
      grant  = 1'b1;
      winner = cand1;
    end else if (eligible[cand2]) begin
      grant  = 1'b1;
      winner = cand2;
    end

    if (state_q == BUSY) begin
      addr_d[sel_q] = bus.lookup_addr;
      done_d[sel_q] = 1'b1;
    end

    if (grant) begin
      state_d      = BUSY;
      sel_d        = winner;
      lookupNote_d = bus.notes[NOTE_W*int'(winner) +: NOTE_W];
      ptr_d        = inc3(winner);
    end
  end

  assign bus.done        = done_q;
  assign bus.addr0       = addr_q[0];
  assign bus.addr1       = addr_q[1];
  assign bus.addr2       = addr_q[2];
  assign bus.lookup_note = lookupNote_q;
  assign bus.busy        = (state_q == BUSY);
endmodule

// File: tb/tb_note_lookup_scheduler.sv
// Scoreboard bench: stimulus pushes expected (voice, address) pairs, a negedge monitor pops one per done strobe.
module tb_note_lookup_scheduler;
  typedef struct packed {
    logic [1:0]  voice;
    logic [44:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  bit   autoDrop = 1'b1;
  exp_t sbQueue[$];

  note_lookup_scheduler_if bus ();

  note_lookup_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the note_address unit: any fixed, note-dependent 45-bit mapping will do.
  function automatic logic [44:0] noteAddrModel(input logic [5:0] n);
    return {n, 39'h0} ^ ({39'h0, n} * 45'd1234567891) ^ 45'h0A5A5A5A5A5;
  endfunction

  assign bus.lookup_addr = noteAddrModel(bus.lookup_note);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [1:0] voice, input logic [5:0] note);
    exp_t e;
    e.voice = voice;
    e.addr  = noteAddrModel(note);
    sbQueue.push_back(e);
  endtask

  // The requester drops req in the cycle it sees its done strobe.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (autoDrop) bus.req = bus.req & ~bus.done;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] reqBits, input logic [5:0] n0, input logic [5:0] n1,
                               input logic [5:0] n2);
    bus.notes = {n2, n1, n0};
    bus.req   = reqBits;
  endtask

  task automatic waitDrain(input string name);
    int cycles = 0;
    while ((sbQueue.size() != 0 || bus.busy) && cycles < 20) begin
      step(1);
      cycles++;
    end
    step(1);
    checkOutput(name, 64'(sbQueue.size()), 64'd0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_note"}, 64'(bus.lookup_note), 64'd0);
    checkOutput({tag, "_addr0"}, 64'(bus.addr0), 64'd0);
    checkOutput({tag, "_addr1"}, 64'(bus.addr1), 64'd0);
    checkOutput({tag, "_addr2"}, 64'(bus.addr2), 64'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.done != 3'b000) begin
        compared++;
        if (sbQueue.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sbUnexpected: got done=%b expected no done", bus.done);
        end else begin
          exp_t e;
          logic [44:0] gotAddr;
          e = sbQueue.pop_front();
          gotAddr = (e.voice == 2'd0) ? bus.addr0 : (e.voice == 2'd1) ? bus.addr1 : bus.addr2;
          if (bus.done !== (3'b001 << e.voice) || gotAddr !== e.addr) begin
            mismatched++;
            $display("[TB] FAIL sbDone: got done=%b addr=%h expected done=%b addr=%h",
                     bus.done, gotAddr, 3'b001 << e.voice, e.addr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] heldPat [8];
    heldPat = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010};
    bus.req   = 3'b000;
    bus.notes = '0;
    step(2);
    checkCleared("reset");
    reset = 1'b0;

    $display("[TB] all voices");
    applyStimulus(3'b111, 6'd4, 6'd12, 6'd22);
    pushExp(2'd0, 6'd4);
    pushExp(2'd1, 6'd12);
    pushExp(2'd2, 6'd22);
    step(1);
    checkOutput("allNote", 64'(bus.lookup_note), 64'd4);
    checkOutput("allBusy0", 64'(bus.busy), 64'd1);
    step(1);
    checkOutput("allBusy1", 64'(bus.busy), 64'd1);
    step(1);
    checkOutput("allBusy2", 64'(bus.busy), 64'd1);
    step(1);
    checkOutput("allBusy3", 64'(bus.busy), 64'd0);
    waitDrain("allDrain");

    $display("[TB] single request and note change");
    applyStimulus(3'b001, 6'd12, 6'd0, 6'd0);
    pushExp(2'd0, 6'd12);
    step(1);
    checkOutput("singleNote", 64'(bus.lookup_note), 64'd12);
    checkOutput("singleOldAddr0", 64'(bus.addr0), 64'(noteAddrModel(6'd4)));
    waitDrain("singleDrain");
    step(3);

    $display("[TB] pointer at voice 1");
    applyStimulus(3'b101, 6'd7, 6'd0, 6'd33);
    pushExp(2'd2, 6'd33);
    pushExp(2'd0, 6'd7);
    waitDrain("rrFrom1Drain");

    $display("[TB] round-robin wrap");
    applyStimulus(3'b100, 6'd0, 6'd0, 6'd50);
    pushExp(2'd2, 6'd50);
    waitDrain("wrapPrimeDrain");
    applyStimulus(3'b101, 6'd9, 6'd0, 6'd60);
    pushExp(2'd0, 6'd9);
    pushExp(2'd2, 6'd60);
    waitDrain("wrapDrain");

    $display("[TB] held request");
    autoDrop = 1'b0;
    applyStimulus(3'b010, 6'd0, 6'd22, 6'd0);
    for (int i = 0; i < 3; i++) pushExp(2'd1, 6'd22);
    for (int c = 0; c < 8; c++) begin
      step(1);
      checkOutput($sformatf("heldDone%0d", c), 64'(bus.done), 64'(heldPat[c]));
      if (c == 6) bus.req = 3'b000;
    end
    autoDrop = 1'b1;
    waitDrain("heldDrain");
    checkOutput("holdNote", 64'(bus.lookup_note), 64'd22);

    $display("[TB] reset mid-flight");
    applyStimulus(3'b010, 6'd0, 6'd40, 6'd0);
    step(1);
    checkOutput("midBusy", 64'(bus.busy), 64'd1);
    reset   = 1'b1;
    bus.req = 3'b000;
    step(1);
    reset = 1'b0;
    checkCleared("midReset");
    step(3);
    applyStimulus(3'b111, 6'd1, 6'd2, 6'd3);
    pushExp(2'd0, 6'd1);
    pushExp(2'd1, 6'd2);
    pushExp(2'd2, 6'd3);
    waitDrain("postResetDrain");

    step(3);
    checkOutput("sbEmpty", 64'(sbQueue.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
